// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and the shared raster count type
//   VGA_H_* / VGA_V_* : default porch, sync and active widths in clocks / lines
//   VGA_*_TOTAL       : derived line length and frame height
//   vga_count_t       : hcount/vcount type shared with the pixel generators
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_MAX_TOTAL = 1024;
  typedef logic [9:0] vga_count_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator and its consumers
//   enable                       : consumer -> generator, stalls the raster when low
//   hcount/vcount/active         : undelayed raster position for the pixel path
//   line_start/frame_start       : pulses aligned with hcount==0 / (0,0)
//   frame_count                  : completed frames, wraps at 256
//   vga_hs/vga_vs/vga_blank_n    : DAC-side sync and blank, pipeline aligned with RGB
//   vga_sync_n                   : sync-on-green, unused and held low
interface vga_timing_gen_if;
  import vga_timing_pkg::*;
  logic enable;
  vga_count_t hcount;
  vga_count_t vcount;
  logic active;
  logic line_start;
  logic frame_start;
  logic [7:0] frame_count;
  logic vga_hs;
  logic vga_vs;
  logic vga_blank_n;
  logic vga_sync_n;
  modport master (
    input enable,
    output hcount, vcount, active, line_start, frame_start, frame_count,
    output vga_hs, vga_vs, vga_blank_n, vga_sync_n
  );
  modport slave (
    output enable,
    input hcount, vcount, active, line_start, frame_start, frame_count,
    input vga_hs, vga_vs, vga_blank_n, vga_sync_n
  );
endinterface

// File: rtl/vga_timing_gen_pipe_delay.sv
// vga_pipe_delay: WIDTH x DEPTH shift register with enable and async active-low clear
//   clk, rst_n : clock, asynchronous clear to INIT on every stage
//   en         : shift when high, hold every stage when low
//   d, q       : input word and word delayed by DEPTH enabled clocks (DEPTH=0 passes through)
module vga_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    assign q = stage[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with sync/blank delayed to match the pixel path
//   vga_clk : pixel clock
//   reset_n : asynchronous active-low reset
//   vif     : master side of vga_timing_gen_if (enable in; counts, pulses, sync, blank out)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int PIPE_DELAY = 1
) (
  input logic vga_clk,
  input logic reset_n,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam vga_count_t H_LAST = vga_count_t'(H_TOTAL - 1);
  localparam vga_count_t V_LAST = vga_count_t'(V_TOTAL - 1);
  localparam vga_count_t H_VIS = vga_count_t'(H_ACTIVE);
  localparam vga_count_t V_VIS = vga_count_t'(V_ACTIVE);
  localparam vga_count_t HS_BEG = vga_count_t'(H_ACTIVE + H_FP);
  localparam vga_count_t HS_LAST = vga_count_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam vga_count_t VS_BEG = vga_count_t'(V_ACTIVE + V_FP);
  localparam vga_count_t VS_LAST = vga_count_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
  if (H_TOTAL > VGA_MAX_TOTAL || V_TOTAL > VGA_MAX_TOTAL) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed %0d", VGA_MAX_TOTAL);
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_delay_check
    $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
  end
  vga_count_t hcount, vcount, h_next, v_next;
  logic [7:0] frame_count;
  logic started, line_start, frame_start, h_last, v_last, active, hs, vs;
  logic [2:0] pipe_q;
  // The first enabled edge after reset only arms the pulses for (0,0); counting starts on the next one.
  always_comb begin
    h_last = hcount == H_LAST;
    v_last = vcount == V_LAST;
    h_next = !started ? hcount : h_last ? '0 : hcount + 10'd1;
    v_next = !(started && h_last) ? vcount : v_last ? '0 : vcount + 10'd1;
    active = hcount < H_VIS && vcount < V_VIS;
    hs = (hcount >= HS_BEG && hcount <= HS_LAST) ? ~SYNC_IDLE : SYNC_IDLE;
    vs = (vcount >= VS_BEG && vcount <= VS_LAST) ? ~SYNC_IDLE : SYNC_IDLE;
  end
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      started <= 1'b0;
      hcount <= '0;
      vcount <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (vif.enable) begin
      started <= 1'b1;
      hcount <= h_next;
      vcount <= v_next;
      line_start <= h_next == '0;
      frame_start <= h_next == '0 && v_next == '0;
      frame_count <= frame_count + {7'd0, started && h_last && v_last};
    end
  // Blank is held low until counting starts so reset reads blanked even with no delay stages.
  vga_pipe_delay #(
    .WIDTH(3),
    .DEPTH(PIPE_DELAY),
    .INIT({SYNC_IDLE, SYNC_IDLE, 1'b0})
  ) u_pipe (
    .clk(vga_clk),
    .rst_n(reset_n),
    .en(vif.enable),
    .d({hs, vs, active && started}),
    .q(pipe_q)
  );
  assign vif.hcount = hcount;
  assign vif.vcount = vcount;
  assign vif.active = active;
  assign vif.line_start = line_start;
  assign vif.frame_start = frame_start;
  assign vif.frame_count = frame_count;
  assign vif.vga_hs = pipe_q[2];
  assign vif.vga_vs = pipe_q[1];
  assign vif.vga_blank_n = pipe_q[0];
  assign vif.vga_sync_n = 1'b0;
endmodule
